// File: rtl/content_loss_pkg.sv
// Shared types and widths for the content-loss sequencer and its accumulator.
package content_loss_pkg;

    localparam int PIX_W      = 16;
    localparam int ACC_W      = 32;
    localparam int CHUNK_SIZE = 64;

    typedef enum logic [2:0] {
        IDLE,
        REQ_C,
        WAIT_C,
        REQ_G,
        WAIT_G,
        ACCUM,
        DONE
    } state_t;

    typedef logic [CHUNK_SIZE-1:0][PIX_W-1:0] chunk_t;

endpackage

// File: rtl/content_loss_acc.sv
// 32-bit loss accumulator with clear and add-enable.
// Define CONTENT_LOSS_SAT_EN to saturate at all-ones instead of wrapping.
module content_loss_acc
    import content_loss_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             add_en,
    input  logic [PIX_W-1:0] add_val,
    output logic [ACC_W-1:0] total
);

    logic [ACC_W-1:0] acc_q;

`ifdef CONTENT_LOSS_SAT_EN
    // Once pinned at all-ones the sum can only carry out again, so it stays there.
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W + 1 - PIX_W){1'b0}}, b};
        acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
    endfunction
`else
    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [PIX_W-1:0] b);
        acc_add = a + {{(ACC_W - PIX_W){1'b0}}, b};
    endfunction
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
        end else if (add_en) begin
            acc_q <= acc_add(acc_q, add_val);
        end
    end

    assign total = acc_q;

endmodule

// File: rtl/content_loss_sequencer.sv
// Fetches content/generated chunk pairs from DDR3, feeds the loss datapath and
// accumulates the per-chunk losses. Optional saturation: CONTENT_LOSS_SAT_EN.
module content_loss_sequencer
    import content_loss_pkg::*;
#(
    parameter int SIZE       = 64,
    parameter int NUM_CHUNKS = 1024,
    parameter int ADDR_W     = 24
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_content,
    input  logic [ADDR_W-1:0]       base_generated,
    output logic                    rd_req,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic                    rd_ready,
    input  logic                    rd_valid,
    input  logic [SIZE*PIX_W-1:0]   rd_data,
    output logic [SIZE*PIX_W-1:0]   dp_content,
    output logic [SIZE*PIX_W-1:0]   dp_generated,
    input  logic [PIX_W-1:0]        dp_loss,
    output logic                    busy,
    output logic                    done,
    output logic [ACC_W-1:0]        loss_total
);

    localparam int K_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_CHUNKS - 1);

    state_t            state;
    state_t            state_next;
    logic [K_W-1:0]    k;
    logic [ADDR_W-1:0] base_c;
    logic [ADDR_W-1:0] base_g;
    logic              acc_clear;
    logic              acc_add_en;
    logic              last_chunk;

    assign last_chunk = (k == K_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_req     = 1'b0;
        acc_clear  = 1'b0;
        acc_add_en = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_clear  = 1'b1;
                    state_next = REQ_C;
                end
            end
            REQ_C: begin
                rd_req = 1'b1;
                if (rd_ready) state_next = WAIT_C;
            end
            WAIT_C: begin
                if (rd_valid) state_next = REQ_G;
            end
            REQ_G: begin
                rd_req = 1'b1;
                if (rd_ready) state_next = WAIT_G;
            end
            WAIT_G: begin
                if (rd_valid) state_next = ACCUM;
            end
            ACCUM: begin
                acc_add_en = 1'b1;
                state_next = last_chunk ? DONE : REQ_C;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bases and k only move outside the REQ states, so rd_addr holds under back-pressure.
    assign rd_addr = ((state == REQ_G) ? base_g : base_c) + ADDR_W'(k);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_c       <= '0;
            base_g       <= '0;
            k            <= '0;
            dp_content   <= '0;
            dp_generated <= '0;
        end else begin
            if (state == IDLE && start) begin
                base_c <= base_content;
                base_g <= base_generated;
                k      <= '0;
            end
            if (state == WAIT_C && rd_valid) dp_content   <= rd_data;
            if (state == WAIT_G && rd_valid) dp_generated <= rd_data;
            if (state == ACCUM && !last_chunk) k <= k + K_W'(1);
        end
    end

    content_loss_acc u_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (acc_clear),
        .add_en  (acc_add_en),
        .add_val (dp_loss),
        .total   (loss_total)
    );

endmodule

// File: tb/tb_content_loss_sequencer.sv
// Self-checking bench: random DDR3 model, behavioural loss datapath and reference totals.
module tb_content_loss_sequencer;

    localparam int SIZE       = 4;
    localparam int NUM_CHUNKS = 4;
    localparam int ADDR_W     = 24;
    localparam int DW         = SIZE * 16;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_content;
    logic [ADDR_W-1:0] base_generated;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ready;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic [DW-1:0]     dp_content;
    logic [DW-1:0]     dp_generated;
    logic [15:0]       dp_loss;
    logic              busy;
    logic              done;
    logic [31:0]       loss_total;

    int n_checks = 0;
    int n_bad    = 0;

    int  ready_delay = 0;
    int  valid_delay = 0;
    bit  spur_en     = 0;
    bit  sat_mode    = 0;
    int  addr_unstable = 0;
    int  done_cnt    = 0;
    logic [ADDR_W-1:0] acc_addrs[$];
    logic [DW-1:0]     mem [logic [ADDR_W-1:0]];

    content_loss_sequencer #(
        .SIZE       (SIZE),
        .NUM_CHUNKS (NUM_CHUNKS),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .base_content   (base_content),
        .base_generated (base_generated),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .dp_content     (dp_content),
        .dp_generated   (dp_generated),
        .dp_loss        (dp_loss),
        .busy           (busy),
        .done           (done),
        .loss_total     (loss_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] chunk_at(input logic [ADDR_W-1:0] a);
        if (!mem.exists(a)) mem[a] = {$urandom, $urandom};
        return mem[a];
    endfunction

    // Sum of absolute pixel differences, truncated to 16 bits.
    function automatic logic [15:0] loss_of(input logic [DW-1:0] c, input logic [DW-1:0] g);
        logic [15:0] s;
        logic [15:0] a;
        logic [15:0] b;
        s = '0;
        for (int i = 0; i < SIZE; i++) begin
            a = c[i*16 +: 16];
            b = g[i*16 +: 16];
            s = s + ((a > b) ? (a - b) : (b - a));
        end
        return s;
    endfunction

    always_comb dp_loss = sat_mode ? 16'hFFFF : loss_of(dp_content, dp_generated);

    function automatic logic [31:0] model_total(input logic [ADDR_W-1:0] bc,
                                                input logic [ADDR_W-1:0] bg);
        logic [31:0] t;
        t = '0;
        for (int k = 0; k < NUM_CHUNKS; k++)
            t = t + 32'(loss_of(chunk_at(bc + ADDR_W'(k)), chunk_at(bg + ADDR_W'(k))));
        return t;
    endfunction

    function automatic int addr_errs(input logic [ADDR_W-1:0] bc, input logic [ADDR_W-1:0] bg);
        int e;
        e = (acc_addrs.size() == 2 * NUM_CHUNKS) ? 0 : 1;
        for (int k = 0; k < NUM_CHUNKS && 2 * k + 1 < acc_addrs.size(); k++) begin
            if (acc_addrs[2*k]   !== bc + ADDR_W'(k)) e++;
            if (acc_addrs[2*k+1] !== bg + ADDR_W'(k)) e++;
        end
        return e;
    endfunction

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    // DDR3 read port model: one outstanding read, programmable ready/valid delays.
    initial begin
        bit pend;
        int rcnt;
        int vcnt;
        bit prev_req;
        logic [ADDR_W-1:0] paddr;
        rd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        pend = 0; rcnt = 0; vcnt = 0; prev_req = 0; paddr = '0;
        forever begin
            @(negedge clk);
            rd_valid = 1'b0;
            if (!reset_n) begin
                pend = 0; rcnt = 0; prev_req = 0; rd_ready = 1'b0;
            end else begin
                if (rd_ready) begin
                    rd_ready = 1'b0;
                    acc_addrs.push_back(paddr);
                    pend = 1; vcnt = valid_delay; rcnt = 0;
                end
                if (pend) begin
                    if (vcnt == 0) begin
                        rd_valid = 1'b1; rd_data = chunk_at(paddr); pend = 0;
                    end else begin
                        vcnt--;
                    end
                end else if (spur_en && $urandom_range(0, 1) == 0) begin
                    rd_valid = 1'b1; rd_data = {$urandom, $urandom};
                end
                if (rd_req === 1'b1) begin
                    if (prev_req) begin
                        if (rd_addr !== paddr) addr_unstable++;
                    end else begin
                        paddr = rd_addr;
                    end
                    if (rcnt >= ready_delay) rd_ready = 1'b1;
                    else rcnt++;
                end
                prev_req = (rd_req === 1'b1);
            end
        end
    end

    task automatic run_pass(input logic [ADDR_W-1:0] bc, input logic [ADDR_W-1:0] bg,
                            input bit poke, output int cyc, output logic [31:0] tot);
        acc_addrs.delete();
        addr_unstable = 0;
        @(negedge clk);
        start = 1'b1; base_content = bc; base_generated = bg;
        @(negedge clk);
        start = 1'b0; base_content = ADDR_W'($urandom); base_generated = ADDR_W'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 1000) begin
            if (poke) begin
                start = ($urandom_range(0, 2) == 0);
                base_content = ADDR_W'($urandom); base_generated = ADDR_W'($urandom);
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (done !== 1'b1) cyc = -1;
        tot = loss_total;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; start = 1'b0; base_content = '0; base_generated = '0;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_req, busy, done} !== 3'b000) begin
            n_bad++; $display("FAIL reset_ctrl: req/busy/done=%b expected 000", {rd_req, busy, done});
        end
        n_checks++;
        if (rd_addr !== '0) begin
            n_bad++; $display("FAIL reset_addr: got %h expected 0", rd_addr);
        end
        n_checks++;
        if (dp_content !== '0 || dp_generated !== '0) begin
            n_bad++; $display("FAIL reset_dp: got %h/%h expected 0", dp_content, dp_generated);
        end
        n_checks++;
        if (loss_total !== 32'h0) begin
            n_bad++; $display("FAIL reset_total: got %h expected 0", loss_total);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_pass(input logic [ADDR_W-1:0] bc, input logic [ADDR_W-1:0] bg,
                                    output logic [31:0] tot);
        int cyc;
        int d0;
        ready_delay = 0; valid_delay = 0;
        d0 = done_cnt;
        run_pass(bc, bg, 1'b0, cyc, tot);
        n_checks++;
        if (cyc != 5 * NUM_CHUNKS + 1) begin
            n_bad++; $display("FAIL single_latency: done at cycle %0d expected %0d", cyc, 5 * NUM_CHUNKS + 1);
        end
        n_checks++;
        if (tot !== model_total(bc, bg)) begin
            n_bad++; $display("FAIL single_total: got %h expected %h", tot, model_total(bc, bg));
        end
        n_checks++;
        if (addr_errs(bc, bg) != 0) begin
            n_bad++; $display("FAIL single_addr_seq: %0d bad addresses of %0d", addr_errs(bc, bg), acc_addrs.size());
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL single_done_pulse: pulses=%0d busy=%b expected 1 and 0", done_cnt - d0, busy);
        end
        n_checks++;
        if (loss_total !== tot) begin
            n_bad++; $display("FAIL single_hold: got %h expected %h", loss_total, tot);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic [31:0] tot;
        logic [ADDR_W-1:0] bc;
        logic [ADDR_W-1:0] bg;
        ready_delay = 0; valid_delay = 0;
        for (int p = 0; p < 2; p++) begin
            bc = ADDR_W'($urandom); bg = ADDR_W'($urandom);
            run_pass(bc, bg, 1'b0, cyc, tot);
            n_checks++;
            if (cyc != 5 * NUM_CHUNKS + 1 || tot !== model_total(bc, bg)) begin
                n_bad++; $display("FAIL b2b_pass%0d: cycle %0d total %h expected %0d %h",
                                  p, cyc, tot, 5 * NUM_CHUNKS + 1, model_total(bc, bg));
            end
        end
    endtask

    task automatic test_backpressure(input logic [ADDR_W-1:0] bc, input logic [ADDR_W-1:0] bg,
                                     input logic [31:0] ref_tot);
        int cyc;
        logic [31:0] tot;
        ready_delay = 3; valid_delay = 2;
        run_pass(bc, bg, 1'b0, cyc, tot);
        n_checks++;
        if (cyc != 15 * NUM_CHUNKS + 1) begin
            n_bad++; $display("FAIL bp_latency: done at cycle %0d expected %0d", cyc, 15 * NUM_CHUNKS + 1);
        end
        n_checks++;
        if (addr_unstable != 0) begin
            n_bad++; $display("FAIL bp_addr_hold: %0d address changes expected 0", addr_unstable);
        end
        n_checks++;
        if (tot !== ref_tot) begin
            n_bad++; $display("FAIL bp_total: got %h expected %h", tot, ref_tot);
        end
        n_checks++;
        if (addr_errs(bc, bg) != 0) begin
            n_bad++; $display("FAIL bp_addr_seq: %0d bad addresses", addr_errs(bc, bg));
        end
    endtask

    task automatic test_start_while_busy(input logic [ADDR_W-1:0] bc, input logic [ADDR_W-1:0] bg,
                                         input logic [31:0] ref_tot);
        int cyc;
        logic [31:0] tot;
        ready_delay = 1; valid_delay = 0; spur_en = 1;
        run_pass(bc, bg, 1'b1, cyc, tot);
        spur_en = 0;
        n_checks++;
        if (cyc != 7 * NUM_CHUNKS + 1) begin
            n_bad++; $display("FAIL busy_latency: done at cycle %0d expected %0d", cyc, 7 * NUM_CHUNKS + 1);
        end
        n_checks++;
        if (tot !== ref_tot) begin
            n_bad++; $display("FAIL busy_total: got %h expected %h", tot, ref_tot);
        end
        n_checks++;
        if (addr_errs(bc, bg) != 0) begin
            n_bad++; $display("FAIL busy_addr_seq: %0d bad addresses", addr_errs(bc, bg));
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL busy_no_restart: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_pass();
        int w;
        int d0;
        int cyc;
        logic [31:0] tot;
        logic [ADDR_W-1:0] bc;
        logic [ADDR_W-1:0] bg;
        ready_delay = 0; valid_delay = 2;
        acc_addrs.delete();
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; base_content = ADDR_W'($urandom); base_generated = ADDR_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (acc_addrs.size() < 4 && w < 200) begin
            @(negedge clk); #1; w++;
        end
        n_checks++;
        if (acc_addrs.size() != 4) begin
            n_bad++; $display("FAIL rst_reach_wait_g: %0d reads accepted expected 4", acc_addrs.size());
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rd_req, busy, done} !== 3'b000 || rd_addr !== '0 || loss_total !== 32'h0
            || dp_content !== '0 || dp_generated !== '0) begin
            n_bad++; $display("FAIL rst_async: req/busy/done=%b addr=%h total=%h expected all 0",
                              {rd_req, busy, done}, rd_addr, loss_total);
        end
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_no_done: pulses=%0d busy=%b expected 0 and 0", done_cnt - d0, busy);
        end
        bc = ADDR_W'($urandom); bg = ADDR_W'($urandom);
        valid_delay = 0;
        run_pass(bc, bg, 1'b0, cyc, tot);
        n_checks++;
        if (cyc != 5 * NUM_CHUNKS + 1 || tot !== model_total(bc, bg)) begin
            n_bad++; $display("FAIL rst_restart: cycle %0d total %h expected %0d %h",
                              cyc, tot, 5 * NUM_CHUNKS + 1, model_total(bc, bg));
        end
    endtask

    task automatic test_addr_wrap();
        int cyc;
        logic [31:0] tot;
        logic [ADDR_W-1:0] bg;
        logic [ADDR_W-1:0] exp_c [4];
        exp_c = '{24'hFFFFFF, 24'h000000, 24'h000001, 24'h000002};
        ready_delay = 0; valid_delay = 0;
        bg = ADDR_W'($urandom);
        run_pass(24'hFFFFFF, bg, 1'b0, cyc, tot);
        for (int k = 0; k < NUM_CHUNKS; k++) begin
            n_checks++;
            if (2 * k >= acc_addrs.size() || acc_addrs[2*k] !== exp_c[k]) begin
                n_bad++; $display("FAIL wrap_addr%0d: got %h expected %h", k,
                                  (2 * k < acc_addrs.size()) ? acc_addrs[2*k] : 24'hx, exp_c[k]);
            end
        end
        n_checks++;
        if (tot !== model_total(24'hFFFFFF, bg)) begin
            n_bad++; $display("FAIL wrap_total: got %h expected %h", tot, model_total(24'hFFFFFF, bg));
        end
    endtask

    task automatic test_saturation();
        int cyc;
        longint sum;
        logic [31:0] expv;
        sat_mode = 1; ready_delay = 0; valid_delay = 0;
        @(negedge clk);
        start = 1'b1; base_content = ADDR_W'($urandom); base_generated = ADDR_W'($urandom);
        @(negedge clk);
        start = 1'b0;
        force dut.u_acc.acc_q = 32'hFFFFFF00;
        @(negedge clk);
        release dut.u_acc.acc_q;
        cyc = 2;
        while (done !== 1'b1 && cyc < 1000) begin
            @(negedge clk); cyc++;
        end
        sum = 64'hFFFFFF00 + longint'(NUM_CHUNKS) * 64'hFFFF;
`ifdef CONTENT_LOSS_SAT_EN
        expv = (sum > 64'hFFFFFFFF) ? 32'hFFFFFFFF : sum[31:0];
`else
        expv = sum[31:0];
`endif
        n_checks++;
        if (done !== 1'b1 || loss_total !== expv) begin
            n_bad++; $display("FAIL sat_total: done=%b total=%h expected %h", done, loss_total, expv);
        end
        sat_mode = 0;
        @(negedge clk);
    endtask

    initial begin
        logic [ADDR_W-1:0] bc;
        logic [ADDR_W-1:0] bg;
        logic [31:0] ref_tot;
        test_reset();
        bc = ADDR_W'($urandom); bg = ADDR_W'($urandom);
        test_single_pass(bc, bg, ref_tot);
        test_back_to_back();
        test_backpressure(bc, bg, ref_tot);
        test_start_while_busy(bc, bg, ref_tot);
        test_reset_mid_pass();
        test_addr_wrap();
        test_saturation();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
